// File: rtl/knap_pkg.sv
// Shared types for the knapsack selection enumerator: item record, FSM states, sum-width helper.
// Item fields are held at KNAP_W_MAX bits; the enumerator supports W up to that width.
package knap_pkg;

   localparam int KNAP_W_MAX = 16;

   typedef struct packed {
      logic [KNAP_W_MAX-1:0] value;
      logic [KNAP_W_MAX-1:0] weight;
      logic [KNAP_W_MAX-1:0] volume;
   } item_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

   // Running sums of n items of w bits each cannot wrap at this width.
   function automatic int knap_sw(input int w, input int n);
      return w + $clog2(n);
   endfunction

endpackage

// File: rtl/knap_gray_step.sv
// Gray-code step decoder: for step counter k, the bit to flip is ctz(k+1);
// dir is that bit's current value in sel (1 = item leaves the selection).
module knap_gray_step #(
   parameter int N_ITEMS = 12
) (
   input  logic [N_ITEMS-1:0]         k,
   input  logic [N_ITEMS-1:0]         sel,
   output logic [$clog2(N_ITEMS)-1:0] j,
   output logic                       dir
);

   localparam int IW = $clog2(N_ITEMS);

   logic [N_ITEMS-1:0] kp;
   logic               found;

   assign kp = k + N_ITEMS'(1);

   always_comb begin
      j     = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N_ITEMS; i++) begin
         if (kp[i] && !found) begin
            j     = IW'(i);
            found = 1'b1;
         end
      end
   end

   assign dir = sel[j];

endmodule

// File: rtl/knap_enumerator.sv
// Walks all 2^N_ITEMS item selections in Gray order with incremental sums and streams the
// feasible ones on a valid/ready port. Define KNAP_BEST_EN to add best-value tracking outputs.
module knap_enumerator
   import knap_pkg::*;
#(
   parameter int N_ITEMS = 12,
   parameter int W       = 8,
   parameter int SW      = knap_sw(W, N_ITEMS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_we,
   input  logic [$clog2(N_ITEMS)-1:0] cfg_idx,
   input  logic [W-1:0]               cfg_value,
   input  logic [W-1:0]               cfg_weight,
   input  logic [W-1:0]               cfg_volume,
   input  logic [W-1:0]               min_value,
   input  logic [W-1:0]               max_weight,
   input  logic [W-1:0]               max_volume,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic                       sol_valid,
   input  logic                       sol_ready,
   output logic [N_ITEMS-1:0]         sol_sel,
   output logic [SW-1:0]              sol_value,
   output logic [N_ITEMS:0]           sol_count
`ifdef KNAP_BEST_EN
   ,
   output logic                       best_found,
   output logic [N_ITEMS-1:0]         best_sel,
   output logic [SW-1:0]              best_value
`endif
);

   localparam int IW = $clog2(N_ITEMS);

   state_t             state;
   item_t              tbl [N_ITEMS];
   item_t              item_j;
   logic [W-1:0]       lim_min;
   logic [W-1:0]       lim_w;
   logic [W-1:0]       lim_v;
   logic [SW-1:0]      sum_value;
   logic [SW-1:0]      sum_weight;
   logic [SW-1:0]      sum_volume;
   logic [SW-1:0]      nxt_value;
   logic [SW-1:0]      nxt_weight;
   logic [SW-1:0]      nxt_volume;
   logic [N_ITEMS-1:0] sel;
   logic [N_ITEMS-1:0] k;
   logic [IW-1:0]      j;
   logic               dir;
   logic               feasible;
   logic               stall;
   logic               last;

   knap_gray_step #(.N_ITEMS(N_ITEMS)) u_step (
      .k   (k),
      .sel (sel),
      .j   (j),
      .dir (dir)
   );

   assign item_j = tbl[j];

   always_comb begin
      feasible   = (sum_value >= SW'(lim_min)) && (sum_weight <= SW'(lim_w)) &&
                   (sum_volume <= SW'(lim_v));
      // A feasible candidate waits only if the slot is full and not draining this cycle.
      stall      = feasible && sol_valid && !sol_ready;
      last       = (k == '1);
      nxt_value  = dir ? sum_value  - SW'(item_j.value)  : sum_value  + SW'(item_j.value);
      nxt_weight = dir ? sum_weight - SW'(item_j.weight) : sum_weight + SW'(item_j.weight);
      nxt_volume = dir ? sum_volume - SW'(item_j.volume) : sum_volume + SW'(item_j.volume);
   end

   // Item table survives reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && cfg_we && 32'(cfg_idx) < N_ITEMS) begin
         tbl[cfg_idx] <= '{value:  KNAP_W_MAX'(cfg_value),
                           weight: KNAP_W_MAX'(cfg_weight),
                           volume: KNAP_W_MAX'(cfg_volume)};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         sol_valid  <= 1'b0;
         sol_sel    <= '0;
         sol_value  <= '0;
         sol_count  <= '0;
         sel        <= '0;
         k          <= '0;
         sum_value  <= '0;
         sum_weight <= '0;
         sum_volume <= '0;
         lim_min    <= '0;
         lim_w      <= '0;
         lim_v      <= '0;
`ifdef KNAP_BEST_EN
         best_found <= 1'b0;
         best_sel   <= '0;
         best_value <= '0;
`endif
      end else begin
         if (sol_valid && sol_ready) sol_valid <= 1'b0;
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  lim_min    <= min_value;
                  lim_w      <= max_weight;
                  lim_v      <= max_volume;
                  sum_value  <= '0;
                  sum_weight <= '0;
                  sum_volume <= '0;
                  sel        <= '0;
                  k          <= '0;
                  sol_count  <= '0;
                  busy       <= 1'b1;
                  state      <= RUN;
`ifdef KNAP_BEST_EN
                  best_found <= 1'b0;
                  best_sel   <= '0;
                  best_value <= '0;
`endif
               end
            end
            RUN: begin
               if (!stall) begin
                  if (feasible) begin
                     sol_valid <= 1'b1;
                     sol_sel   <= sel;
                     sol_value <= sum_value;
                     sol_count <= sol_count + (N_ITEMS+1)'(1);
`ifdef KNAP_BEST_EN
                     if (!best_found || sum_value > best_value) begin
                        best_found <= 1'b1;
                        best_sel   <= sel;
                        best_value <= sum_value;
                     end
`endif
                  end
                  if (last) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= FIN;
                  end else begin
                     sel[j]     <= ~dir;
                     k          <= k + N_ITEMS'(1);
                     sum_value  <= nxt_value;
                     sum_weight <= nxt_weight;
                     sum_volume <= nxt_volume;
                  end
               end
            end
            FIN: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_knap_enumerator.sv
// Self-checking bench for knap_enumerator (N_ITEMS=4): directed scenarios plus randomized
// item tables and backpressure against a direct enumeration model of the selection rules.
module tb_knap_enumerator;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int SW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_we;
   logic [1:0]    cfg_idx;
   logic [W-1:0]  cfg_value, cfg_weight, cfg_volume;
   logic [W-1:0]  min_value, max_weight, max_volume;
   logic          start;
   logic          busy, done, sol_valid, sol_ready;
   logic [N-1:0]  sol_sel;
   logic [SW-1:0] sol_value;
   logic [N:0]    sol_count;
`ifdef KNAP_BEST_EN
   logic          best_found;
   logic [N-1:0]  best_sel;
   logic [SW-1:0] best_value;
`endif

   knap_enumerator #(.N_ITEMS(N), .W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_idx    (cfg_idx),
      .cfg_value  (cfg_value),
      .cfg_weight (cfg_weight),
      .cfg_volume (cfg_volume),
      .min_value  (min_value),
      .max_weight (max_weight),
      .max_volume (max_volume),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .sol_valid  (sol_valid),
      .sol_ready  (sol_ready),
      .sol_sel    (sol_sel),
      .sol_value  (sol_value),
      .sol_count  (sol_count)
`ifdef KNAP_BEST_EN
      ,
      .best_found (best_found),
      .best_sel   (best_sel),
      .best_value (best_value)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   int iv[N], iw[N], ivol[N];

   logic [N-1:0]  got_sel[$];
   logic [SW-1:0] got_val[$];
   logic [N-1:0]  exp_sel[$];
   logic [SW-1:0] exp_val[$];
   bit            exp_best_found;
   logic [N-1:0]  exp_best_sel;
   logic [SW-1:0] exp_best_val;

   int   done_at, done_pulses, cnt_at_done;
   logic busy1, busy_done;

   // Reference: evaluate every selection in reflected-Gray order from scratch.
   function automatic void model(input int mn, input int mw, input int mv);
      exp_sel.delete();
      exp_val.delete();
      exp_best_found = 0;
      exp_best_sel   = '0;
      exp_best_val   = '0;
      for (int k = 0; k < (1 << N); k++) begin
         int g, sv, sw, so;
         g = k ^ (k >> 1);
         sv = 0; sw = 0; so = 0;
         for (int i = 0; i < N; i++) begin
            if ((g >> i) & 1) begin
               sv += iv[i]; sw += iw[i]; so += ivol[i];
            end
         end
         if (sv >= mn && sw <= mw && so <= mv) begin
            exp_sel.push_back(N'(g));
            exp_val.push_back(SW'(sv));
            if (!exp_best_found || sv > int'(exp_best_val)) begin
               exp_best_found = 1;
               exp_best_sel   = N'(g);
               exp_best_val   = SW'(sv);
            end
         end
      end
   endfunction

   task automatic load_item(input int idx, input int v, input int w, input int vol);
      @(negedge clk);
      cfg_we = 1'b1; cfg_idx = 2'(idx);
      cfg_value = 8'(v); cfg_weight = 8'(w); cfg_volume = 8'(vol);
      @(negedge clk);
      cfg_we = 1'b0;
      iv[idx] = v; iw[idx] = w; ivol[idx] = vol;
   endtask

   task automatic load_basic();
      load_item(0, 4, 28, 27);
      load_item(1, 8, 8, 27);
      load_item(2, 0, 27, 4);
      load_item(3, 20, 18, 4);
   endtask

   // mode 0: ready high; 1: ready low 10 cycles from first solution;
   // 2: random ready; 3: start/cfg_we pulsed while busy.
   task automatic do_run(input int mn, input int mw, input int mv, input int mode);
      int n, bp_left;
      bit bp_on;
      got_sel.delete();
      got_val.delete();
      done_at = -1; done_pulses = 0; cnt_at_done = -1;
      busy1 = 1'bx; busy_done = 1'bx;
      @(negedge clk);
      min_value = 8'(mn); max_weight = 8'(mw); max_volume = 8'(mv);
      start = 1'b1; sol_ready = 1'b1;
      n = 0; bp_left = 0; bp_on = 0;
      while (n < 600) begin
         @(negedge clk);
         n++;
         if (n == 1) begin start = 1'b0; busy1 = busy; end
         if (mode == 3 && n == 2) begin
            start = 1'b1; cfg_we = 1'b1; cfg_idx = 2'd3;
            cfg_value = '0; cfg_weight = '0; cfg_volume = '0;
         end
         if (mode == 3 && n == 3) begin start = 1'b0; cfg_we = 1'b0; end
         if (mode == 1) begin
            if (bp_left > 0) begin
               bp_left--;
               if (bp_left == 0) sol_ready = 1'b1;
            end
            if (!bp_on && sol_valid) begin
               bp_on = 1; bp_left = 10; sol_ready = 1'b0;
            end
         end
         if (mode == 2) sol_ready = (done_at >= 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (sol_valid && sol_ready) begin
            got_sel.push_back(sol_sel);
            got_val.push_back(sol_value);
         end
         if (done) begin
            done_pulses++;
            if (done_at < 0) begin done_at = n; cnt_at_done = int'(sol_count); busy_done = busy; end
         end
         if (done_at >= 0 && n > done_at + 1 && !sol_valid) break;
      end
      sol_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp += 6;
      if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
      if (sol_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", sol_valid); end
      if (sol_sel !== '0)     begin n_err++; $display("FAIL reset_sel: got %b want 0", sol_sel); end
      if (sol_value !== '0)   begin n_err++; $display("FAIL reset_value: got %0d want 0", sol_value); end
      if (sol_count !== '0)   begin n_err++; $display("FAIL reset_count: got %0d want 0", sol_count); end
`ifdef KNAP_BEST_EN
      n_cmp++;
      if ({best_found, best_sel, best_value} !== '0) begin
         n_err++; $display("FAIL reset_best: got %b/%b/%0d want 0", best_found, best_sel, best_value);
      end
`endif
      rst = 1'b0;
   endtask

   // Shared by every scenario that must reproduce the basic run's two solutions.
   task automatic test_basic_like(input string tag, input int want_done);
      logic [N-1:0]  ws[2];
      logic [SW-1:0] wv[2];
      ws[0] = 4'b1010; wv[0] = 10'd28;
      ws[1] = 4'b1000; wv[1] = 10'd20;
      n_cmp++;
      if (got_sel.size() != 2) begin
         n_err++; $display("FAIL %s_nsol: got %0d want 2", tag, got_sel.size());
      end
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (i >= got_sel.size()) begin
            n_err++; $display("FAIL %s_sol%0d: missing, want %b/%0d", tag, i, ws[i], wv[i]);
         end else if (got_sel[i] !== ws[i] || got_val[i] !== wv[i]) begin
            n_err++; $display("FAIL %s_sol%0d: got %b/%0d want %b/%0d", tag, i,
                              got_sel[i], got_val[i], ws[i], wv[i]);
         end
      end
      n_cmp += 5;
      if (done_at != want_done) begin n_err++; $display("FAIL %s_done_at: got %0d want %0d", tag, done_at, want_done); end
      if (cnt_at_done != 2)     begin n_err++; $display("FAIL %s_count: got %0d want 2", tag, cnt_at_done); end
      if (busy1 !== 1'b1)       begin n_err++; $display("FAIL %s_busy_t1: got %b want 1", tag, busy1); end
      if (busy_done !== 1'b0)   begin n_err++; $display("FAIL %s_busy_done: got %b want 0", tag, busy_done); end
      if (done_pulses != 1)     begin n_err++; $display("FAIL %s_done_pulses: got %0d want 1", tag, done_pulses); end
`ifdef KNAP_BEST_EN
      n_cmp++;
      if (best_found !== 1'b1 || best_sel !== 4'b1010 || best_value !== 10'd28) begin
         n_err++; $display("FAIL %s_best: got %b/%b/%0d want 1/1010/28", tag, best_found, best_sel, best_value);
      end
`endif
   endtask

   task automatic test_basic();
      load_basic();
      do_run(20, 30, 40, 0);
      test_basic_like("basic", 17);
   endtask

   task automatic test_backpressure();
      do_run(20, 30, 40, 1);
      // Candidate 15 stalls for cycles 16..23 while the first solution is held.
      test_basic_like("bp", 25);
   endtask

   task automatic test_min_zero();
      model(0, 255, 255);
      do_run(0, 255, 255, 0);
      n_cmp += 4;
      if (got_sel.size() != 16) begin n_err++; $display("FAIL minz_nsol: got %0d want 16", got_sel.size()); end
      if (got_sel.size() == 0 || got_sel[0] !== 4'b0000) begin
         n_err++; $display("FAIL minz_first: got %b want 0000", got_sel.size() ? got_sel[0] : 4'bxxxx);
      end
      if (cnt_at_done != 16) begin n_err++; $display("FAIL minz_count: got %0d want 16", cnt_at_done); end
      if (done_at != 17)     begin n_err++; $display("FAIL minz_done_at: got %0d want 17", done_at); end
      for (int i = 0; i < exp_sel.size() && i < got_sel.size(); i++) begin
         n_cmp++;
         if (got_sel[i] !== exp_sel[i] || got_val[i] !== exp_val[i]) begin
            n_err++; $display("FAIL minz_sol%0d: got %b/%0d want %b/%0d", i, got_sel[i], got_val[i],
                              exp_sel[i], exp_val[i]);
         end
      end
   endtask

   task automatic test_ignore_busy();
      do_run(20, 30, 40, 3);
      test_basic_like("ignore", 17);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      min_value = 8'd0; max_weight = 8'd255; max_volume = 8'd255;
      start = 1'b1; sol_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      // Cycle t+5: candidate 4 under evaluation, four solutions already taken.
      n_cmp += 2;
      if (busy !== 1'b1)      begin n_err++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
      if (sol_count !== 5'd4) begin n_err++; $display("FAIL rmid_count_before: got %0d want 4", sol_count); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if ({busy, done, sol_valid, sol_sel, sol_value, sol_count} !== '0) begin
         n_err++; $display("FAIL rmid_outputs: got busy=%b done=%b valid=%b sel=%b value=%0d count=%0d want all 0",
                           busy, done, sol_valid, sol_sel, sol_value, sol_count);
      end
`ifdef KNAP_BEST_EN
      n_cmp++;
      if ({best_found, best_sel, best_value} !== '0) begin
         n_err++; $display("FAIL rmid_best: got %b/%b/%0d want 0", best_found, best_sel, best_value);
      end
`endif
      do_run(20, 30, 40, 0);
      test_basic_like("rmid_rerun", 17);
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         int mn, mw, mv;
         for (int i = 0; i < N; i++)
            load_item(i, $urandom_range(0, 60), $urandom_range(0, 80), $urandom_range(0, 80));
         mn = $urandom_range(0, 90);
         mw = $urandom_range(40, 255);
         mv = $urandom_range(40, 255);
         model(mn, mw, mv);
         do_run(mn, mw, mv, 2);
         n_cmp += 3;
         if (got_sel.size() != exp_sel.size()) begin
            n_err++; $display("FAIL rand%0d_nsol: got %0d want %0d", it, got_sel.size(), exp_sel.size());
         end
         if (cnt_at_done != exp_sel.size()) begin
            n_err++; $display("FAIL rand%0d_count: got %0d want %0d", it, cnt_at_done, exp_sel.size());
         end
         if (done_at < 17) begin
            n_err++; $display("FAIL rand%0d_done_at: got %0d want >=17", it, done_at);
         end
         for (int i = 0; i < exp_sel.size() && i < got_sel.size(); i++) begin
            n_cmp++;
            if (got_sel[i] !== exp_sel[i] || got_val[i] !== exp_val[i]) begin
               n_err++; $display("FAIL rand%0d_sol%0d: got %b/%0d want %b/%0d", it, i,
                                 got_sel[i], got_val[i], exp_sel[i], exp_val[i]);
            end
         end
`ifdef KNAP_BEST_EN
         n_cmp++;
         if (best_found !== exp_best_found || (exp_best_found &&
             (best_sel !== exp_best_sel || best_value !== exp_best_val))) begin
            n_err++; $display("FAIL rand%0d_best: got %b/%b/%0d want %b/%b/%0d", it, best_found,
                              best_sel, best_value, exp_best_found, exp_best_sel, exp_best_val);
         end
`endif
      end
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0;
      cfg_value = '0; cfg_weight = '0; cfg_volume = '0;
      min_value = '0; max_weight = '0; max_volume = '0;
      start = 1'b0; sol_ready = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_min_zero();
      test_ignore_busy();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
